// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch prediction/resolution path.
// Carries the IF->ID->EX prediction metadata and counter helpers.
package branch_resolve_unit_pkg;

    typedef struct packed {
        logic        pred_taken;
        logic [31:0] pred_target;
    } bpred_meta_t;

    localparam logic [1:0] BHT_INIT = 2'b01;

    localparam bpred_meta_t META_BUBBLE = '{pred_taken: 1'b0, pred_target: 32'd0};

    function automatic logic [1:0] sat_update(input logic [1:0] c, input logic t);
        logic [1:0] n;
        n = c;
        if (t && c != 2'b11) n = c + 2'd1;
        if (!t && c != 2'b00) n = c - 2'd1;
        return n;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_bht.sv
// 2-bit saturating-counter direction table.
// Flop based: combinational read, write on the clock edge.
module bht_array
    import branch_resolve_unit_pkg::*;
#(
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rindex,
    input  logic [IDX_W-1:0] windex,
    input  logic             update,
    input  logic             taken,
    output logic [1:0]       ctr
);

    localparam int DEPTH = 2 ** IDX_W;

    logic [1:0] r_tbl [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_tbl[i] <= BHT_INIT;
        end else if (update) begin
            r_tbl[windex] <= sat_update(r_tbl[windex], taken);
        end
    end

    // Read sees the pre-edge value, so a same-index write shows up next cycle.
    assign ctr = r_tbl[rindex];

endmodule

// File: rtl/branch_resolve_unit.sv
// Fetch-time taken/not-taken decision for the BTB, metadata pipe,
// EX-stage resolution, BTB write generation and perf counters.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int IDX_W = 10,
    parameter int TAG_W = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [31:0]      if_pc,
    input  logic [31:0]      if_btb_target,
    input  logic             ex_valid,
    input  logic             ex_is_br,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    input  logic [31:0]      ex_pc,
    output logic             if_pred_taken,
    output logic [31:0]      if_next_pc,
    output logic             load_btb,
    output logic [31:0]      btb_wr_target,
    output logic [31:0]      btb_wr_pc,
    output logic             mispredict,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int DEPTH = 2 ** IDX_W;

    logic [DEPTH-1:0] r_valid;
    logic [TAG_W-1:0] r_tag [DEPTH];
    bpred_meta_t      r_id_meta;
    bpred_meta_t      r_ex_meta;
    logic [CNT_W-1:0] r_br_count;
    logic [CNT_W-1:0] r_mispred_count;

    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic [IDX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0] w_ex_tag;
    logic [1:0]       w_ctr;
    logic             w_hit;
    logic             w_br_mis;
    logic             w_alias_mis;
    logic             w_mis;
    logic             w_upd;

    assign w_if_idx = if_pc[IDX_W+1:2];
    assign w_if_tag = if_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign w_ex_idx = ex_pc[IDX_W+1:2];
    assign w_ex_tag = ex_pc[IDX_W+TAG_W+1:IDX_W+2];

    bht_array #(.IDX_W(IDX_W)) u_bht (
        .clk    (clk),
        .rst    (rst),
        .rindex (w_if_idx),
        .windex (w_ex_idx),
        .update (w_upd),
        .taken  (ex_taken),
        .ctr    (w_ctr)
    );

    assign w_hit         = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign if_pred_taken = !rst && w_hit && w_ctr[1];
    assign if_next_pc    = if_pred_taken ? if_btb_target : if_pc + 32'd4;

    assign w_br_mis = ex_is_br &&
        ((r_ex_meta.pred_taken != ex_taken) ||
         (ex_taken && r_ex_meta.pred_target != ex_target));
    // A predicted-taken non-branch came from a tag/index alias.
    assign w_alias_mis = !ex_is_br && r_ex_meta.pred_taken;
    assign w_mis       = ex_valid && !rst && !stall && (w_br_mis || w_alias_mis);
    assign w_upd       = ex_valid && ex_is_br && !stall && !rst;

    assign mispredict    = w_mis;
    assign redirect_pc   = ex_taken ? ex_target : ex_pc + 32'd4;
    assign load_btb      = w_upd && ex_taken;
    assign btb_wr_target = ex_target;
    assign btb_wr_pc     = ex_pc;
    assign br_count      = r_br_count;
    assign mispred_count = r_mispred_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid         <= '0;
            r_id_meta       <= META_BUBBLE;
            r_ex_meta       <= META_BUBBLE;
            r_br_count      <= '0;
            r_mispred_count <= '0;
        end else if (!stall) begin
            if (w_mis) begin
                r_id_meta <= META_BUBBLE;
                r_ex_meta <= META_BUBBLE;
            end else begin
                r_id_meta <= '{pred_taken: if_pred_taken, pred_target: if_btb_target};
                r_ex_meta <= r_id_meta;
            end
            if (w_upd) begin
                r_br_count <= r_br_count + CNT_W'(1);
                if (w_mis) r_mispred_count <= r_mispred_count + CNT_W'(1);
                if (ex_taken) r_valid[w_ex_idx] <= 1'b1;
            end
        end
    end

    // Tags need no reset: valid gates every lookup.
    always_ff @(posedge clk) begin
        if (load_btb) r_tag[w_ex_idx] <= w_ex_tag;
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: driver pushes expectations,
// negedge monitor pops and compares.
module tb_branch_resolve_unit;

    typedef struct {
        int          id;
        logic        pt;
        logic [31:0] npc;
        logic        ld;
        logic [31:0] wtgt;
        logic [31:0] wpc;
        logic        mis;
        logic [31:0] rpc;
        logic [31:0] br;
        logic [31:0] mc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic [31:0] if_pc = '0;
    logic [31:0] if_btb_target = '0;
    logic        ex_valid = 1'b0;
    logic        ex_is_br = 1'b0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_target = '0;
    logic [31:0] ex_pc = '0;
    logic        if_pred_taken;
    logic [31:0] if_next_pc;
    logic        load_btb;
    logic [31:0] btb_wr_target;
    logic [31:0] btb_wr_pc;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    int   checks = 0;
    int   errors = 0;
    int   vnum = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    branch_resolve_unit #(.IDX_W(10), .TAG_W(8), .CNT_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .if_pc         (if_pc),
        .if_btb_target (if_btb_target),
        .ex_valid      (ex_valid),
        .ex_is_br      (ex_is_br),
        .ex_taken      (ex_taken),
        .ex_target     (ex_target),
        .ex_pc         (ex_pc),
        .if_pred_taken (if_pred_taken),
        .if_next_pc    (if_next_pc),
        .load_btb      (load_btb),
        .btb_wr_target (btb_wr_target),
        .btb_wr_pc     (btb_wr_pc),
        .mispredict    (mispredict),
        .redirect_pc   (redirect_pc),
        .br_count      (br_count),
        .mispred_count (mispred_count)
    );

    task automatic chk(input int id, input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL v%0d %s got %h want %h", id, n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.id, "if_pred_taken", 32'(if_pred_taken), 32'(e.pt));
            chk(e.id, "if_next_pc", if_next_pc, e.npc);
            chk(e.id, "load_btb", 32'(load_btb), 32'(e.ld));
            chk(e.id, "btb_wr_target", btb_wr_target, e.wtgt);
            chk(e.id, "btb_wr_pc", btb_wr_pc, e.wpc);
            chk(e.id, "mispredict", 32'(mispredict), 32'(e.mis));
            chk(e.id, "redirect_pc", redirect_pc, e.rpc);
            chk(e.id, "br_count", br_count, e.br);
            chk(e.id, "mispred_count", mispred_count, e.mc);
        end
    end

    task automatic s(
        input logic r, input logic st,
        input logic [31:0] ipc, input logic [31:0] itgt,
        input logic ev, input logic eb, input logic et,
        input logic [31:0] etgt, input logic [31:0] epc,
        input logic pt, input logic [31:0] npc, input logic ld,
        input logic mis, input logic [31:0] rpc,
        input logic [31:0] br, input logic [31:0] mc
    );
        exp_t e;
        rst = r;
        stall = st;
        if_pc = ipc;
        if_btb_target = itgt;
        ex_valid = ev;
        ex_is_br = eb;
        ex_taken = et;
        ex_target = etgt;
        ex_pc = epc;
        vnum++;
        e = '{id: vnum, pt: pt, npc: npc, ld: ld, wtgt: etgt, wpc: epc,
              mis: mis, rpc: rpc, br: br, mc: mc};
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        // held in reset with a taken branch presented: all gated off
        s(1,0, 32'h100,32'h200, 1,1,1, 32'h200,32'h100, 0,32'h104,0,0,32'h200, 0,0);
        s(0,0, 32'h100,32'h200, 0,0,0, 32'h0,32'h0, 0,32'h104,0,0,32'h4, 0,0);
        s(0,0, 32'h500,32'h0, 1,1,1, 32'h200,32'h100, 0,32'h504,1,1,32'h200, 0,0);
        s(0,0, 32'h100,32'h200, 0,0,0, 32'h0,32'h0, 1,32'h200,0,0,32'h4, 1,1);
        s(0,0, 32'h204,32'h0, 0,0,0, 32'h0,32'h0, 0,32'h208,0,0,32'h4, 1,1);
        // predicted taken, resolves not taken; same-index fetch sees old bht
        s(0,0, 32'h100,32'h200, 1,1,0, 32'h200,32'h100, 1,32'h200,0,1,32'h104, 1,1);
        s(0,0, 32'h100,32'h200, 0,0,0, 32'h0,32'h0, 0,32'h104,0,0,32'h4, 2,2);
        s(0,0, 32'h600,32'h0, 1,1,1, 32'h200,32'h100, 0,32'h604,1,1,32'h200, 2,2);
        s(0,0, 32'h100,32'h200, 0,0,0, 32'h0,32'h0, 1,32'h200,0,0,32'h4, 3,3);
        s(0,0, 32'h700,32'h0, 0,0,0, 32'h0,32'h0, 0,32'h704,0,0,32'h4, 3,3);
        // JALR with wrong predicted target
        s(0,0, 32'h800,32'h0, 1,1,1, 32'h300,32'h100, 0,32'h804,1,1,32'h300, 3,3);
        s(0,0, 32'h100,32'h300, 0,0,0, 32'h0,32'h0, 1,32'h300,0,0,32'h4, 4,4);
        s(0,0, 32'h900,32'h0, 0,0,0, 32'h0,32'h0, 0,32'h904,0,0,32'h4, 4,4);
        // three stalled cycles, then release
        for (int i = 0; i < 3; i++)
            s(0,1, 32'h900,32'h0, 1,1,1, 32'h400,32'h100, 0,32'h904,0,0,32'h400, 4,4);
        s(0,0, 32'h900,32'h0, 1,1,1, 32'h400,32'h100, 0,32'h904,1,1,32'h400, 4,4);
        s(0,0, 32'h100,32'h400, 0,0,0, 32'h0,32'h0, 1,32'h400,0,0,32'h4, 5,5);
        // alias: same index, different tag
        s(0,0, 32'h1100,32'h400, 0,0,0, 32'h0,32'h0, 0,32'h1104,0,0,32'h4, 5,5);
        // correctly predicted taken branch
        s(0,0, 32'ha00,32'h0, 1,1,1, 32'h400,32'h100, 0,32'ha04,1,0,32'h400, 5,5);
        s(0,0, 32'h100,32'h400, 0,0,0, 32'h0,32'h0, 1,32'h400,0,0,32'h4, 6,5);
        s(0,0, 32'hb00,32'h0, 0,0,0, 32'h0,32'h0, 0,32'hb04,0,0,32'h4, 6,5);
        // non-branch arriving with pred_taken=1
        s(0,0, 32'hc00,32'h0, 1,0,0, 32'h0,32'h100, 0,32'hc04,0,1,32'h104, 6,5);
        s(0,0, 32'h100,32'h400, 0,0,0, 32'h0,32'h0, 1,32'h400,0,0,32'h4, 6,5);
        // reset mid-operation
        s(1,0, 32'h100,32'h400, 1,1,1, 32'h400,32'h100, 0,32'h104,0,0,32'h400, 6,5);
        s(0,0, 32'h100,32'h400, 0,0,0, 32'h0,32'h0, 0,32'h104,0,0,32'h4, 0,0);
        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
